// File: rtl/frame_sequencer_if.sv
// Object result port of the frame sequencer: captured centroid plus its id,
// offered to a downstream consumer with a valid/ready handshake.
interface frame_sequencer_if #(
  parameter int ID_W = 8
);
  logic [15:0]     cx;
  logic [15:0]     cy;
  logic [ID_W-1:0] cid;
  logic            obj_valid;
  logic            obj_ready;

  // Sequencer side: produces the object, consumes ready.
  modport master (
    output cx,
    output cy,
    output cid,
    output obj_valid,
    input  obj_ready
  );

  // Consumer side: receives the object, drives ready.
  modport slave (
    input  cx,
    input  cy,
    input  cid,
    input  obj_valid,
    output obj_ready
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame of pixel coordinates into the detection
// pipeline, drains it with a fixed number of flush cycles, then steps obj_id
// through every detected label and hands each centroid out on a valid/ready
// port. One completed frame bumps the frame counter and pulses done.
module frame_sequencer #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int FLUSH_CYCLES = 16,
  parameter int RD_LAT       = 2,
  parameter int ID_W         = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            pix_valid,
  output logic            en,
  output logic [15:0]     x,
  output logic [15:0]     y,
  input  logic [ID_W-1:0] num_labels,
  output logic [ID_W-1:0] obj_id,
  input  logic [15:0]     obj_x,
  input  logic [15:0]     obj_y,
  frame_sequencer_if.master obj,
  output logic            busy,
  output logic            done,
  output logic [15:0]     frame
);

  localparam logic [15:0] X_LAST     = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST     = 16'(HEIGHT - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  // WAIT lasts RD_LAT+1 cycles so top's read data has settled before capture.
  localparam logic [7:0]  WAIT_LAST  = 8'(RD_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_SNAP,
    ST_WAIT,
    ST_HOLD,
    ST_FIN
  } state_t;

  state_t          state;
  logic [15:0]     flush_cnt;
  logic [7:0]      wait_cnt;
  logic [ID_W-1:0] count;

  // Enable follows the source while streaming; forced high while draining.
  assign en = ((state == ST_STREAM) && pix_valid) || (state == ST_FLUSH);

  // Frame sequencing FSM with all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      obj_id        <= '0;
      obj.cx        <= '0;
      obj.cy        <= '0;
      obj.cid       <= '0;
      obj.obj_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame         <= '0;
      flush_cnt     <= '0;
      wait_cnt      <= '0;
      count         <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over every other event, including a same-cycle start.
        state         <= ST_IDLE;
        busy          <= 1'b0;
        x             <= '0;
        y             <= '0;
        obj.obj_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_STREAM;
              busy  <= 1'b1;
              x     <= '0;
              y     <= '0;
            end
          end

          ST_STREAM: begin
            if (pix_valid) begin
              if (x == X_LAST) begin
                if (y == Y_LAST) begin
                  // Last pixel: coordinates stay parked on it during flush.
                  state     <= ST_FLUSH;
                  flush_cnt <= '0;
                end else begin
                  x <= '0;
                  y <= y + 16'd1;
                end
              end else begin
                x <= x + 16'd1;
              end
            end
          end

          ST_FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state <= ST_SNAP;
            end else begin
              flush_cnt <= flush_cnt + 16'd1;
            end
          end

          ST_SNAP: begin
            // Label count is frozen here; later changes on num_labels are ignored.
            count <= num_labels;
            if (num_labels == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
              frame <= frame + 16'd1;
            end else begin
              state    <= ST_WAIT;
              obj_id   <= ID_W'(1);
              wait_cnt <= '0;
            end
          end

          ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state         <= ST_HOLD;
              obj.cx        <= obj_x;
              obj.cy        <= obj_y;
              obj.cid       <= obj_id;
              obj.obj_valid <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end

          ST_HOLD: begin
            if (obj.obj_ready) begin
              obj.obj_valid <= 1'b0;
              // Compare before increment so a full-scale count never wraps obj_id.
              if (obj_id == count) begin
                state <= ST_FIN;
                done  <= 1'b1;
                frame <= frame + 16'd1;
              end else begin
                state    <= ST_WAIT;
                obj_id   <= obj_id + ID_W'(1);
                wait_cnt <= '0;
              end
            end
          end

          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Sequences one frame through the detection pipeline (top). It streams pixels while generating x/y coordinates and the pipeline enable, then drains the pipeline for a fixed number of flush cycles. It then walks obj_id from 1 to the latched label count, presenting each object's centroid on a valid/ready output port. It sits between the pixel source and top, replacing the free-running location generator and the manual obj_id stepping.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame
FLUSH_CYCLES, 16, enable-high cycles after the last pixel to drain the pipeline (>=1)
RD_LAT, 2, cycles from an obj_id change to valid obj_x/obj_y from top (>=1)
ID_W, 8, width of obj_id and num_labels

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a frame when IDLE, ignored otherwise
abort  in  1  synchronous abort to IDLE
pix_valid  in  1  source has a pixel on data this cycle
en  out  1  pipeline enable to top
x  out  16  pixel column to top
y  out  16  pixel row to top
num_labels  in  ID_W  label count from top
obj_id  out  ID_W  object select to top
obj_x  in  16  centroid x from top
obj_y  in  16  centroid y from top
cx  out  16  captured centroid x
cy  out  16  captured centroid y
cid  out  ID_W  id of the captured object
obj_valid  out  1  cx/cy/cid valid
obj_ready  in  1  consumer accepts the object
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion
frame  out  16  completed-frame counter

Behaviour:
- Reset (async, reset_n=0): state=IDLE. en, obj_valid, done, busy, x, y, cx, cy, cid, frame all 0. obj_id=0.
- All outputs are registered. Clock and reset are as stated above: single clock clk, asynchronous active-low reset_n.
- IDLE: en=0. When start=1, go to STREAM with x=0, y=0.
- STREAM:
  - en = pix_valid (combinational gate of a registered state).
  - On each cycle with pix_valid=1: if x==WIDTH-1 then x<=0 and y<=y+1, else x<=x+1.
  - When pix_valid=1 with x==WIDTH-1 and y==HEIGHT-1, go to FLUSH. x/y hold at the last pixel.
  - pix_valid=0 holds x, y and state.
- FLUSH: en=1 for exactly FLUSH_CYCLES cycles with x/y frozen, then go to SNAP.
- SNAP (1 cycle): en=0. Latch num_labels into an internal count.
  - count==0: go to FIN.
  - otherwise: obj_id<=1 and go to WAIT.
- WAIT: after RD_LAT cycles, capture cx<=obj_x, cy<=obj_y, cid<=obj_id, set obj_valid=1, and go to HOLD.
- HOLD:
  - obj_valid stays 1 and cx/cy/cid stay stable until obj_ready=1.
  - On handshake: obj_valid<=0 in the same edge.
    - obj_id==count: go to FIN.
    - otherwise: obj_id<=obj_id+1 and go to WAIT.
  - obj_ready with obj_valid=0 has no effect.
- FIN (1 cycle): done=1, frame<=frame+1 (wraps 0xFFFF->0), then IDLE. obj_id holds its last value.
- abort=1 in any state: next edge goes to IDLE with en=0, obj_valid=0, x=y=0. frame is not incremented and done is not pulsed.
- Simultaneous events:
  - abort takes priority over everything.
  - start and abort in the same IDLE cycle: stay IDLE.
  - start while busy: ignored.
- num_labels changes after SNAP: ignored. A count of 2^ID_W-1 is supported without obj_id overflow.
- Latency:
  - start to first en: 1 cycle.
  - last pixel to SNAP: FLUSH_CYCLES+1 cycles.
  - obj_id change to obj_valid: RD_LAT+1 cycles.

Test Plan:
1. WIDTH=4, HEIGHT=3, pix_valid held 1, start pulse -> en high 12+FLUSH_CYCLES consecutive cycles. x/y sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), then frozen at (3,2).
2. Same frame with pix_valid toggling 1,0,1,0 -> x/y advance only on valid cycles, en mirrors pix_valid, 24 cycles to finish streaming.
3. num_labels=3, obj_ready tied 1, top model returns obj_x=10*id, obj_y=20*id -> cid/cx/cy = (1,10,20),(2,20,40),(3,30,60), each RD_LAT+1 cycles after obj_id changes. Then done pulses once and frame=1.
4. num_labels=0 -> SNAP goes directly to FIN, obj_valid never asserts, done pulses, frame increments.
5. obj_ready held 0 for 7 cycles during HOLD -> obj_valid and cx/cy/cid stable for all 7 cycles. obj_id does not advance until the handshake cycle.
6. abort during STREAM at (2,1), and separately reset_n=0 during HOLD -> IDLE next edge (reset: immediately). en=0, obj_valid=0, frame unchanged. A new start then restarts at (0,0).
